// File: rtl/mmio_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_responder_pkg
//  Description : Shared constants for the memory-mapped I/O responder.
//                Holds the I/O region tag (addr[31:28]) and the register
//                offsets decoded on addr[7:0], plus a small zero-extend helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mmio_responder_pkg;

    // Top nibble of the address that selects the I/O region
    localparam logic [3:0] IO_REGION    = 4'b1000;

    // Register offsets within the region (addr[7:0])
    localparam logic [7:0] IO_UART_CTRL = 8'h00;
    localparam logic [7:0] IO_UART_RX   = 8'h04;
    localparam logic [7:0] IO_UART_TX   = 8'h08;
    localparam logic [7:0] IO_CYC_CNT   = 8'h10;
    localparam logic [7:0] IO_INST_CNT  = 8'h14;
    localparam logic [7:0] IO_CNT_RST   = 8'h18;

    // Zero-extend a byte to a full read word
    function automatic logic [31:0] zext8(input logic [7:0] b);
        return {24'h00_0000, b};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_responder_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with a registered occupancy count and a
//                first-word-fall-through head (dout shows the oldest entry
//                whenever empty is low). Push while full and pop while empty
//                are ignored, so a simultaneous push/pop on an empty FIFO
//                stores the byte and leaves the read pointer alone.
//  Ports       : clk, rst   - clock, synchronous active-high reset
//                push, din  - write request and data
//                pop        - read request (advances the head)
//                dout       - current head entry
//                full/empty - decoded from the registered count
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8      // power of 2, at least 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    logic w_do_push;
    logic w_do_pop;

    assign full      = (count_q == C_FULL_COUNT);
    assign empty     = (count_q == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop  && !empty;
    assign dout      = mem_q[rd_ptr_q];

    // Storage carries no reset; validity is tracked by the count alone
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of 2
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (w_do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mmio_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_responder
//  Description : Memory-mapped I/O responder for the core data path. Decodes
//                loads/stores in region addr[31:28]==4'b1000 and returns the
//                read word one cycle later, matching DMEM latency. Owns the
//                UART TX holding register, the RX byte FIFO and the cycle /
//                retired-instruction counters.
//  Ports       : clk, rst              - clock, synchronous active-high reset
//                addr, wdata, wmask    - stage-2 access address / store data
//                load_en, store_en     - stage-2 access type
//                stall                 - suppresses every access side effect
//                inst_retire           - instruction-counter increment
//                dout                  - registered read data
//                tx_data/valid/ready   - UART transmit handshake
//                rx_data/valid/ready   - UART receive handshake
//  Revision    : 1.0 - initial release
// ============================================================================
module mmio_responder
    import mmio_responder_pkg::*;
#(
    parameter int RX_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    input  logic        load_en,
    input  logic        store_en,
    input  logic        stall,
    input  logic        inst_retire,
    output logic [31:0] dout,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    logic       w_sel;
    logic       w_load;
    logic       w_store;
    logic [7:0] w_off;

    assign w_sel   = (addr[31:28] == IO_REGION) && !stall;
    assign w_load  = w_sel && load_en;
    assign w_store = w_sel && store_en;
    assign w_off   = addr[7:0];

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [7:0] w_fifo_dout;
    logic       w_fifo_full;
    logic       w_fifo_empty;
    logic       w_push;
    logic       w_pop;

    // rst is folded in so the receiver never sees ready during reset
    assign rx_ready = ~w_fifo_full & ~rst;
    assign w_push   = rx_valid & rx_ready;
    // Popping an empty FIFO is ignored inside the FIFO itself
    assign w_pop    = w_load && (w_off == IO_UART_RX);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (rx_data),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [31:0] dout_q,     dout_d;
    logic [7:0]  tx_data_q,  tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic [31:0] cyc_q,      cyc_d;
    logic [31:0] inst_q,     inst_d;
    logic [31:0] w_rdata;
    logic        w_cnt_clr;

    // Read mux: all sources are registered state, so dout has no
    // combinational path from the address/enables to the outside.
    always_comb begin
        w_rdata = 32'h0;
        case (w_off)
            IO_UART_CTRL: w_rdata = {30'h0, ~w_fifo_empty, ~tx_valid_q};
            IO_UART_RX:   w_rdata = w_fifo_empty ? 32'h0 : zext8(w_fifo_dout);
            IO_CYC_CNT:   w_rdata = cyc_q;
            IO_INST_CNT:  w_rdata = inst_q;
            default:      w_rdata = 32'h0;
        endcase
    end

    assign w_cnt_clr = w_store && (w_off == IO_CNT_RST);

    always_comb begin
        dout_d     = w_load ? w_rdata : dout_q;

        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        // A busy holding register drops the store even if the handshake
        // completes in the same cycle.
        if (tx_valid_q) begin
            if (tx_ready) begin
                tx_valid_d = 1'b0;
            end
        end else if (w_store && (w_off == IO_UART_TX) && wmask[0]) begin
            tx_data_d  = wdata[7:0];
            tx_valid_d = 1'b1;
        end

        // Clear wins over increment
        if (w_cnt_clr) begin
            cyc_d  = 32'h0;
            inst_d = 32'h0;
        end else begin
            cyc_d  = cyc_q + 32'd1;
            inst_d = inst_q + {31'h0, inst_retire};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q     <= 32'h0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            cyc_q      <= 32'h0;
            inst_q     <= 32'h0;
        end else begin
            dout_q     <= dout_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            cyc_q      <= cyc_d;
            inst_q     <= inst_d;
        end
    end

    assign dout     = dout_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mmio_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mmio_responder
//  Description : Self-checking bench for mmio_responder. One vector = one
//                clock cycle of stimulus plus the expected outputs after the
//                edge that ends it. Reset is exercised by hand around the table.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_responder;

    typedef struct {
        logic        ld;
        logic        st;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  wm;
        logic        stl;
        logic        ret;
        logic        txr;
        logic        rxv;
        logic [7:0]  rxd;
        logic [31:0] e_dout;
        logic        e_txv;
        logic [7:0]  e_txd;
        logic        e_rxr;
    } vec_t;

    localparam logic [31:0] A_CTRL = 32'h8000_0000;
    localparam logic [31:0] A_RX   = 32'h8000_0004;
    localparam logic [31:0] A_TX   = 32'h8000_0008;
    localparam logic [31:0] A_CYC  = 32'h8000_0010;
    localparam logic [31:0] A_INST = 32'h8000_0014;
    localparam logic [31:0] A_CRST = 32'h8000_0018;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        load_en;
    logic        store_en;
    logic        stall;
    logic        inst_retire;
    logic [31:0] dout;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;

    int n_tests = 0;
    int n_fail  = 0;

    vec_t vq[$];

    mmio_responder #(.RX_DEPTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .addr        (addr),
        .wdata       (wdata),
        .wmask       (wmask),
        .load_en     (load_en),
        .store_en    (store_en),
        .stall       (stall),
        .inst_retire (inst_retire),
        .dout        (dout),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic ld, input logic st, input logic [31:0] a,
        input logic [7:0] wd, input logic [3:0] wm,
        input logic stl, input logic ret, input logic txr,
        input logic rxv, input logic [7:0] rxd,
        input logic [31:0] ed, input logic etv, input logic [7:0] etd,
        input logic err);
        vec_t v;
        v.ld = ld; v.st = st; v.a = a;
        v.wd = {24'hA5A5A5, wd}; v.wm = wm;
        v.stl = stl; v.ret = ret; v.txr = txr;
        v.rxv = rxv; v.rxd = rxd;
        v.e_dout = ed; v.e_txv = etv; v.e_txd = etd; v.e_rxr = err;
        return v;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic set_idle();
        load_en = 1'b0; store_en = 1'b0; addr = 32'h0; wdata = 32'h0;
        wmask = 4'h0; stall = 1'b0; inst_retire = 1'b0; tx_ready = 1'b0;
        rx_valid = 1'b0; rx_data = 8'h00;
    endtask

    // Drive one cycle, then check the outputs just after the edge
    task automatic apply(input vec_t v, input int idx);
        load_en = v.ld; store_en = v.st; addr = v.a; wdata = v.wd;
        wmask = v.wm; stall = v.stl; inst_retire = v.ret; tx_ready = v.txr;
        rx_valid = v.rxv; rx_data = v.rxd;
        @(posedge clk);
        #1;
        chk("dout",     idx, dout,              v.e_dout);
        chk("tx_valid", idx, {31'h0, tx_valid}, {31'h0, v.e_txv});
        chk("tx_data",  idx, {24'h0, tx_data},  {24'h0, v.e_txd});
        chk("rx_ready", idx, {31'h0, rx_ready}, {31'h0, v.e_rxr});
    endtask

    initial begin
        //                 ld st addr          wd     wm    stl ret txr rxv rxd     exp_dout       txv txd    rxr
        // --- status / TX ---
        vq.push_back(mk(1, 0, A_CTRL,        8'h00, 4'h0, 0, 0, 0, 0, 8'h00, 32'h1,         0, 8'h00, 1));
        vq.push_back(mk(0, 1, A_TX,          8'h41, 4'h1, 0, 0, 0, 0, 8'h00, 32'h1,         1, 8'h41, 1));
        vq.push_back(mk(1, 0, A_CTRL,        8'h00, 4'h0, 0, 0, 0, 0, 8'h00, 32'h0,         1, 8'h41, 1));
        vq.push_back(mk(0, 1, A_TX,          8'h42, 4'hF, 0, 0, 0, 0, 8'h00, 32'h0,         1, 8'h41, 1));
        vq.push_back(mk(0, 0, 32'h0,         8'h00, 4'h0, 0, 0, 1, 0, 8'h00, 32'h0,         0, 8'h41, 1));
        vq.push_back(mk(0, 1, A_TX,          8'h43, 4'hE, 0, 0, 0, 0, 8'h00, 32'h0,         0, 8'h41, 1));
        vq.push_back(mk(0, 1, A_TX,          8'h66, 4'hF, 1, 0, 0, 0, 8'h00, 32'h0,         0, 8'h41, 1));
        vq.push_back(mk(1, 0, A_CTRL,        8'h00, 4'h0, 0, 0, 0, 0, 8'h00, 32'h1,         0, 8'h41, 1));
        vq.push_back(mk(1, 0, A_TX,          8'h00, 4'h0, 0, 0, 0, 0, 8'h00, 32'h0,         0, 8'h41, 1));
        vq.push_back(mk(1, 0, 32'h8ABC_D000, 8'h00, 4'h0, 0, 0, 0, 0, 8'h00, 32'h1,         0, 8'h41, 1));
        vq.push_back(mk(1, 0, 32'h8000_000C, 8'h00, 4'h0, 0, 0, 0, 0, 8'h00, 32'h0,         0, 8'h41, 1));
        vq.push_back(mk(1, 0, A_CTRL,        8'h00, 4'h0, 0, 0, 0, 0, 8'h00, 32'h1,         0, 8'h41, 1));
        vq.push_back(mk(1, 0, A_CRST,        8'h00, 4'h0, 0, 0, 0, 0, 8'h00, 32'h0,         0, 8'h41, 1));
        // --- fill FIFO with 01..08 ---
        for (int i = 1; i <= 8; i++)
            vq.push_back(mk(0, 0, 32'h0, 8'h00, 4'h0, 0, 0, 0, 1, 8'(i), 32'h0, 0, 8'h41, (i < 8)));
        vq.push_back(mk(0, 0, 32'h0,         8'h00, 4'h0, 0, 0, 0, 1, 8'h09, 32'h0,         0, 8'h41, 0));
        vq.push_back(mk(1, 0, A_CTRL,        8'h00, 4'h0, 0, 0, 0, 0, 8'h00, 32'h3,         0, 8'h41, 0));
        // --- drain in order ---
        for (int i = 1; i <= 8; i++)
            vq.push_back(mk(1, 0, A_RX, 8'h00, 4'h0, 0, 0, 0, 0, 8'h00, 32'(i), 0, 8'h41, 1));
        vq.push_back(mk(1, 0, A_RX,          8'h00, 4'h0, 0, 0, 0, 0, 8'h00, 32'h0,         0, 8'h41, 1));
        vq.push_back(mk(1, 0, A_CTRL,        8'h00, 4'h0, 0, 0, 0, 0, 8'h00, 32'h1,         0, 8'h41, 1));
        // --- push+pop on empty, then on non-empty ---
        vq.push_back(mk(1, 0, A_RX,          8'h00, 4'h0, 0, 0, 0, 1, 8'hAA, 32'h0,         0, 8'h41, 1));
        vq.push_back(mk(1, 0, A_CTRL,        8'h00, 4'h0, 0, 0, 0, 0, 8'h00, 32'h3,         0, 8'h41, 1));
        vq.push_back(mk(1, 0, A_RX,          8'h00, 4'h0, 0, 0, 0, 0, 8'h00, 32'hAA,        0, 8'h41, 1));
        vq.push_back(mk(0, 0, 32'h0,         8'h00, 4'h0, 0, 0, 0, 1, 8'h11, 32'hAA,        0, 8'h41, 1));
        vq.push_back(mk(1, 0, A_RX,          8'h00, 4'h0, 0, 0, 0, 1, 8'h22, 32'h11,        0, 8'h41, 1));
        vq.push_back(mk(1, 0, A_RX,          8'h00, 4'h0, 0, 0, 0, 0, 8'h00, 32'h22,        0, 8'h41, 1));
        vq.push_back(mk(1, 0, A_RX,          8'h00, 4'h0, 0, 0, 0, 0, 8'h00, 32'h0,         0, 8'h41, 1));
        // --- stall, non-I/O and read-only store leave state alone ---
        vq.push_back(mk(1, 0, A_CTRL,        8'h00, 4'h0, 0, 0, 0, 1, 8'h33, 32'h1,         0, 8'h41, 1));
        vq.push_back(mk(1, 0, A_CTRL,        8'h00, 4'h0, 0, 0, 0, 0, 8'h00, 32'h3,         0, 8'h41, 1));
        vq.push_back(mk(1, 0, A_RX,          8'h00, 4'h0, 1, 0, 0, 0, 8'h00, 32'h3,         0, 8'h41, 1));
        vq.push_back(mk(1, 0, 32'h1000_0004, 8'h00, 4'h0, 0, 0, 0, 0, 8'h00, 32'h3,         0, 8'h41, 1));
        vq.push_back(mk(0, 1, 32'h1000_0008, 8'h55, 4'hF, 0, 0, 0, 0, 8'h00, 32'h3,         0, 8'h41, 1));
        vq.push_back(mk(0, 1, A_RX,          8'h55, 4'hF, 0, 0, 0, 0, 8'h00, 32'h3,         0, 8'h41, 1));
        vq.push_back(mk(1, 0, A_RX,          8'h00, 4'h0, 0, 0, 0, 0, 8'h00, 32'h33,        0, 8'h41, 1));
        vq.push_back(mk(1, 0, A_RX,          8'h00, 4'h0, 0, 0, 0, 0, 8'h00, 32'h0,         0, 8'h41, 1));
        // --- counters (clear gives absolute values) ---
        vq.push_back(mk(0, 1, A_CRST,        8'h00, 4'hF, 0, 0, 0, 0, 8'h00, 32'h0,         0, 8'h41, 1));
        vq.push_back(mk(1, 0, A_INST,        8'h00, 4'h0, 0, 0, 0, 0, 8'h00, 32'h0,         0, 8'h41, 1));
        vq.push_back(mk(1, 0, A_CYC,         8'h00, 4'h0, 0, 0, 0, 0, 8'h00, 32'h1,         0, 8'h41, 1));
        vq.push_back(mk(1, 0, A_CYC,         8'h00, 4'h0, 0, 0, 0, 0, 8'h00, 32'h2,         0, 8'h41, 1));
        vq.push_back(mk(1, 0, A_CYC,         8'h00, 4'h0, 1, 0, 0, 0, 8'h00, 32'h2,         0, 8'h41, 1));
        vq.push_back(mk(1, 0, A_CYC,         8'h00, 4'h0, 0, 0, 0, 0, 8'h00, 32'h4,         0, 8'h41, 1));
        for (int i = 0; i < 5; i++)
            vq.push_back(mk(0, 0, 32'h0, 8'h00, 4'h0, 0, 1, 0, 0, 8'h00, 32'h4, 0, 8'h41, 1));
        vq.push_back(mk(1, 0, A_INST,        8'h00, 4'h0, 0, 0, 0, 0, 8'h00, 32'h5,         0, 8'h41, 1));
        vq.push_back(mk(0, 1, A_CRST,        8'h00, 4'hF, 0, 1, 0, 0, 8'h00, 32'h5,         0, 8'h41, 1));
        vq.push_back(mk(1, 0, A_INST,        8'h00, 4'h0, 0, 0, 0, 0, 8'h00, 32'h0,         0, 8'h41, 1));
        // --- load a byte and a TX word before the mid-operation reset ---
        vq.push_back(mk(0, 0, 32'h0,         8'h00, 4'h0, 0, 0, 0, 1, 8'h77, 32'h0,         0, 8'h41, 1));
        vq.push_back(mk(0, 1, A_TX,          8'h5A, 4'h1, 0, 0, 0, 0, 8'h00, 32'h0,         1, 8'h5A, 1));

        // Power-on reset
        set_idle();
        rst = 1'b1;
        #1;
        chk("rx_ready_in_reset", 0, {31'h0, rx_ready}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dout",     0, dout,              32'h0);
        chk("reset_tx_valid", 0, {31'h0, tx_valid}, 32'h0);
        chk("reset_tx_data",  0, {24'h0, tx_data},  32'h0);
        rst = 1'b0;
        #1;
        chk("rx_ready_after_reset", 0, {31'h0, rx_ready}, 32'h1);

        for (int i = 0; i < vq.size(); i++)
            apply(vq[i], i + 1);

        // Reset while a TX byte is pending and the FIFO holds 0x77
        set_idle();
        rst = 1'b1;
        #1;
        chk("mid_rst_rx_ready", 100, {31'h0, rx_ready}, 32'h0);
        @(posedge clk);
        #1;
        chk("mid_rst_tx_valid", 100, {31'h0, tx_valid}, 32'h0);
        chk("mid_rst_tx_data",  100, {24'h0, tx_data},  32'h0);
        rst = 1'b0;
        #1;
        chk("mid_rst_rx_ready_rel", 100, {31'h0, rx_ready}, 32'h1);
        apply(mk(1, 0, A_CTRL, 8'h00, 4'h0, 0, 0, 0, 0, 8'h00, 32'h1, 0, 8'h00, 1), 101);
        apply(mk(1, 0, A_RX,   8'h00, 4'h0, 0, 0, 0, 0, 8'h00, 32'h0, 0, 8'h00, 1), 102);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mmio_responder.md
# mmio_responder

Memory-mapped I/O responder for the riscv_core data path. It serves loads and stores whose address top nibble is 4'b1000, producing the I/O read word for the stage-3 read controller with the same one-cycle latency as DMEM. It owns the UART transmit holding register, an RX byte FIFO, and the cycle and instruction counters.

## Interface
- RX_DEPTH, 8: RX FIFO depth in bytes; must be a power of 2, at least 2.
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- addr  in  32  stage-2 ALU address
- wdata  in  32  stage-2 store data, already lane-shifted by the write controller
- wmask  in  4  byte write mask from the write controller
- load_en  in  1  stage-2 instruction is a load
- store_en  in  1  stage-2 instruction is a store
- stall  in  1  pipeline stall; suppresses all access side effects
- inst_retire  in  1  one instruction retired this cycle
- dout  out  32  registered I/O read data; drives the read controller's io_data_in
- tx_data  out  8  byte to the UART transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  UART transmitter accepts tx_data
- rx_data  in  8  byte from the UART receiver
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  FIFO can accept a byte

## Operation
- An access is a load or a store with addr[31:28]==4'b1000, load_en or store_en high, and stall low.
- Other addresses are ignored entirely. Offsets are decoded on addr[7:0]; addr[27:8] are don't-care.
- 0x00 UART control, read-only: bit0 = ~tx_valid (TX free), bit1 = RX FIFO non-empty, other bits 0.
- 0x04 RX data, read-only: returns {24'b0, FIFO head} and pops one byte. If the FIFO is empty, it returns 0 and the pointers do not move.
- 0x08 TX data, write-only: when wmask[0]=1 and tx_valid=0, latches wdata[7:0] into tx_data and sets tx_valid. If tx_valid=1, the store is dropped.
- 0x10 cycle counter, 32-bit, read-only: increments every cycle, including stalled cycles, and wraps at 2^32.
- 0x14 instruction counter, 32-bit, read-only: increments when inst_retire=1 and wraps at 2^32.
- 0x18 counter reset, write-only: any store here clears both counters; clear takes priority over increment in that cycle.
- Loads from unmapped offsets, and loads from write-only offsets, return 0.
- Stores to read-only or unmapped offsets have no effect.
- TX handshake:
  - tx_valid is held with tx_data stable until the first cycle where tx_valid and tx_ready are both high.
  - tx_valid clears on the next edge.
- RX handshake:
  - A byte is pushed when rx_valid and rx_ready are both high.
  - rx_ready = ~full && ~rst, combinational from the registered count.
- Simultaneous push and pop:
  - Non-empty FIFO: both happen and the count is unchanged.
  - Empty FIFO: the pop returns 0 and the byte is stored.
  - Full FIFO: rx_ready is 0, so only the pop happens.
- A store to 0x08 and a TX handshake in the same cycle: the handshake completes and the new store is dropped, because tx_valid was 1 when the store was presented.
- Reset values: dout=0, tx_data=0, tx_valid=0, both counters 0, FIFO empty (rx_ready=0 during reset, 1 after).
- Reset mid-operation discards any pending TX byte and all FIFO contents.

## Timing
- Read latency 1:
  - dout updates on the edge ending the access cycle.
  - It holds until the next I/O load access, including through stall and non-I/O cycles.
- Counter reads return the counter value registered before that edge, i.e. the pre-increment value.
- Status read in cycle N reflects tx_valid and FIFO count at the start of cycle N.
- Pop, TX latch and counter clear all take effect on the edge ending the access cycle.
- No combinational path from addr, load_en or store_en to any output. The only combinational path is rst to rx_ready.

## Structure
- Shared package holds:
  - IO_REGION = 4'b1000
  - offsets IO_UART_CTRL=8'h00, IO_UART_RX=8'h04, IO_UART_TX=8'h08, IO_CYC_CNT=8'h10, IO_INST_CNT=8'h14, IO_CNT_RST=8'h18.
- Sub-module sync_fifo:
  - parameters WIDTH=8, DEPTH=RX_DEPTH
  - ports clk, rst, push, pop, din, dout, full, empty
  - registered count; first-word-fall-through head.
- The top level holds the address decode, TX register, counters and the dout register.

## Test plan
- Reset, then load 0x80000000 → dout=32'h0000_0001; rx_ready=1; tx_valid=0.
- Store 32'h0000_0041 to 0x80000008 with tx_ready=0 → tx_valid=1, tx_data=8'h41. A second store of 8'h42 is dropped. Raise tx_ready for one cycle → tx_valid=0 next cycle, and tx_data was never 8'h42.
- Push bytes 8'h01..8'h08 → rx_ready=0 after the 8th. Push 8'h09 with rx_valid → not accepted. Eight loads of 0x80000004 → 8'h01..8'h08 in order. A ninth load → dout=0 and status bit1=0.
- Empty FIFO: push 8'hAA and load 0x80000004 in the same cycle → dout=0. A following load → 8'hAA.
- Load 0x80000010 on consecutive cycles → values differ by 1. Set inst_retire=1 for 5 cycles, then load 0x80000014 → 5.
  - Store to 0x80000018 → the next load of 0x80000014 returns 0, and 0x80000010 returns 1 when read one cycle after the clear.
- Load 0x80000004 with stall=1 on a non-empty FIFO → no pop and dout unchanged.
  - Load 0x10000000 → dout unchanged.
  - Assert rst mid-TX → tx_valid=0 and the FIFO is empty.
